seq_normalizer: RTL and testbench
=================================

Name: seq_normalizer

Overview:
- Multi-cycle count-leading-zeros/ones unit with normalizer for the pipeline CPU EX stage; serves MIPS CLZ/CLO.
- Acts as the inverse of the 5-stage shift network: given an operand, it recovers the left-shift amount that normalizes it.
- Performs a 5-step binary search (16/8/4/2/1), one step per cycle.
- Uses a valid/ready handshake on input and output. One operation is in flight at a time.

Parameters:
- OP_CLZ, 1'b0, Op_sel encoding for count-leading-zeros.
- OP_CLO, 1'b1, Op_sel encoding for count-leading-ones.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- In_valid  input  1  operand and op presented.
- In_ready  output  1  unit can accept an operation.
- Op_sel  input  1  OP_CLZ or OP_CLO; sampled at accept.
- Norm_in  input  32  operand; sampled at accept.
- Flush  input  1  synchronous abort from pipeline flush.
- Out_valid  output  1  result available.
- Out_ready  input  1  consumer takes result.
- Lead_count  output  6  leading zero/one count, range 0..32.
- Norm_out  output  32  operand shifted left by Lead_count, zero-filled.

Behaviour:
- States:
  - IDLE: In_ready=1.
  - RUN: 3-bit step counter k = 4..0.
  - DONE: Out_valid=1.
- Reset (async, rst_n=0): state IDLE, Out_valid=0, Lead_count=0, Norm_out=0, step counter=4, working regs cleared. In_ready=1 only after rst_n deasserts.
- Accept: an edge with IDLE & In_valid.
  - Latch work=Norm_in, target bit t = (Op_sel==OP_CLO), cnt=0, k=4.
  - Go to RUN.
- RUN, one step per edge, width w=2^k:
  - If work[31:32-w] are all equal to t: work <= work<<w (zero-fill), cnt <= cnt+w.
  - Otherwise work and cnt are unchanged.
  - k decrements each edge.
- Final fixup (in the same edge as step k=0): if the post-step work[31]==t, then cnt += 1 and work <= work<<1.
  - This yields 32 for an all-t operand. Norm_out is then 0.
- Timing:
  - The edge at which step k=0 is applied moves RUN to DONE.
  - Out_valid is high exactly 5 edges after the accept edge.
- Outputs are registered. Lead_count/Norm_out are stable while Out_valid=1.
- DONE: hold until Out_ready=1; at that edge go to IDLE and Out_valid falls. There is no same-cycle re-accept; In_ready=0 in RUN and DONE.
- Backpressure: Out_ready low holds result and state indefinitely.
- Flush: synchronous, highest priority after reset.
  - From any state go to IDLE; Out_valid=0 next edge; result discarded.
  - Flush with In_valid in IDLE does not accept.
- Reset mid-operation aborts immediately; no result is produced.
- Op_sel/Norm_in changes after accept have no effect.
- Width rules: cnt is 6 bits and cannot overflow (max 16+8+4+2+1+1=32).

Decomposition:
- Package seq_normalizer_pkg:
  - OP_CLZ/OP_CLO constants.
  - State encoding IDLE/RUN/DONE (2 bits).
  - Step counter width.
  - DATA_W=32 and CNT_W=6.
- Sub-module norm_step (combinational): inputs work, k, t; outputs next work and increment. Includes the fixup-bit logic, selected when k==0.
- The FSM, handshake and registers stay in seq_normalizer.

Test Plan:
- CLZ 0x00000000 accepted at edge 0 -> Out_valid at edge 5, Lead_count=32, Norm_out=0x00000000.
- CLZ 0x00010000 -> Lead_count=15, Norm_out=0x80000000.
- CLZ 0x80000000 -> Lead_count=0, Norm_out=0x80000000.
- CLO 0xFFFFFFFF -> Lead_count=32, Norm_out=0.
- CLO 0xF0000000 -> Lead_count=4, Norm_out=0x00000000.
- CLO 0x7FFFFFFF -> Lead_count=0.
- Out_ready held low 3 cycles after Out_valid -> result and Out_valid stable, In_ready=0, new In_valid ignored.
  - Out_ready=1 -> IDLE next edge, In_ready=1.
- Flush at edge 2 of RUN (operand 0x00000001) -> IDLE next edge, no Out_valid.
  - A following CLZ 0x00000001 -> Lead_count=31, Norm_out=0x80000000.
- rst_n pulsed low mid-RUN -> Out_valid=0, In_ready=1 after release, Lead_count=0, Norm_out=0.
  - The next operation completes normally in 5 cycles.

Source files
------------

// File: rtl/seq_normalizer_pkg.sv
// Shared constants and types for the leading zero/one counter.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package seq_normalizer_pkg;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 6;
  localparam int STEP_W = 3;

  // Op_sel encodings
  localparam logic OP_CLZ = 1'b0;
  localparam logic OP_CLO = 1'b1;

  // First search step: width 2^4 = 16 bits
  localparam logic [STEP_W-1:0] STEP_FIRST = 3'd4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

endpackage

// File: rtl/seq_normalizer_if.sv
// Handshake and data bundle between the EX stage and the normalizer.
// Latency: n/a (wiring only).
// Backpressure: Out_ready from the consumer, In_ready from the unit.
interface seq_normalizer_if;
  import seq_normalizer_pkg::*;

  logic              In_valid;
  logic              In_ready;
  logic              Op_sel;
  logic [DATA_W-1:0] Norm_in;
  logic              Flush;
  logic              Out_valid;
  logic              Out_ready;
  logic [CNT_W-1:0]  Lead_count;
  logic [DATA_W-1:0] Norm_out;

  // Pipeline side: presents operations and consumes results
  modport master (
    output In_valid, Op_sel, Norm_in, Flush, Out_ready,
    input  In_ready, Out_valid, Lead_count, Norm_out
  );

  // Normalizer side
  modport slave (
    input  In_valid, Op_sel, Norm_in, Flush, Out_ready,
    output In_ready, Out_valid, Lead_count, Norm_out
  );
endinterface

// File: rtl/seq_normalizer_norm_step.sv
// One binary-search step of width 2^k, plus the final single-bit fixup at k==0.
// Latency: combinational.
// Backpressure: none; the caller decides when to register the result.
module norm_step
  import seq_normalizer_pkg::*;
(
  input  logic [DATA_W-1:0] work_i,
  input  logic [STEP_W-1:0] k_i,
  input  logic              t_i,
  output logic [DATA_W-1:0] work_o,
  output logic [CNT_W-1:0]  inc_o
);

  logic [CNT_W-1:0]  width;
  logic [DATA_W-1:0] top_mask;
  logic [DATA_W-1:0] stepped;
  logic              hit;

  // Shift out the top 2^k bits when they all equal the target bit; at k==0 also
  // absorb one more target bit so an all-target operand counts to 32.
  always_comb begin
    width    = CNT_W'(1) << k_i;
    top_mask = ~({DATA_W{1'b1}} >> width);
    hit      = ((work_i ^ {DATA_W{t_i}}) & top_mask) == '0;
    stepped  = hit ? (work_i << width) : work_i;
    work_o   = stepped;
    inc_o    = hit ? width : '0;
    if (k_i == '0 && stepped[DATA_W-1] == t_i) begin
      work_o = stepped << 1;
      inc_o  = inc_o + CNT_W'(1);
    end
  end

endmodule

// File: rtl/seq_normalizer.sv
// Multi-cycle CLZ/CLO with normalized operand, 5-step binary search (16/8/4/2/1).
// Latency: result valid 5 edges after accept; one operation in flight.
// Backpressure: result and state held while Out_ready is low; In_ready low in RUN/DONE.
module seq_normalizer
  import seq_normalizer_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  seq_normalizer_if.slave bus
);

  state_t            state_q;
  logic [STEP_W-1:0] k_q;
  logic [DATA_W-1:0] work_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              t_q;
  logic              in_rdy_q;
  logic              out_vld_q;
  logic [CNT_W-1:0]  lead_q;
  logic [DATA_W-1:0] norm_q;

  logic [DATA_W-1:0] work_d;
  logic [CNT_W-1:0]  inc;
  logic [CNT_W-1:0]  cnt_d;

  norm_step u_step (
    .work_i (work_q),
    .k_i    (k_q),
    .t_i    (t_q),
    .work_o (work_d),
    .inc_o  (inc)
  );

  // Running count after the current step
  always_comb begin
    cnt_d = cnt_q + inc;
  end

  // Control FSM with registered handshake and result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      k_q       <= STEP_FIRST;
      work_q    <= '0;
      cnt_q     <= '0;
      t_q       <= 1'b0;
      in_rdy_q  <= 1'b0;
      out_vld_q <= 1'b0;
      lead_q    <= '0;
      norm_q    <= '0;
    end else if (bus.Flush) begin
      // Abort whatever is in flight; no accept in the flush cycle
      state_q   <= ST_IDLE;
      k_q       <= STEP_FIRST;
      in_rdy_q  <= 1'b1;
      out_vld_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (in_rdy_q && bus.In_valid) begin
            work_q   <= bus.Norm_in;
            t_q      <= (bus.Op_sel == OP_CLO);
            cnt_q    <= '0;
            k_q      <= STEP_FIRST;
            in_rdy_q <= 1'b0;
            state_q  <= ST_RUN;
          end else begin
            // Also raises In_ready on the first edge after reset release
            in_rdy_q <= 1'b1;
          end
        end
        ST_RUN: begin
          work_q <= work_d;
          cnt_q  <= cnt_d;
          if (k_q == '0) begin
            lead_q    <= cnt_d;
            norm_q    <= work_d;
            out_vld_q <= 1'b1;
            k_q       <= STEP_FIRST;
            state_q   <= ST_DONE;
          end else begin
            k_q <= k_q - STEP_W'(1);
          end
        end
        ST_DONE: begin
          if (bus.Out_ready) begin
            out_vld_q <= 1'b0;
            in_rdy_q  <= 1'b1;
            state_q   <= ST_IDLE;
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          in_rdy_q  <= 1'b1;
          out_vld_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.In_ready   = in_rdy_q;
  assign bus.Out_valid  = out_vld_q;
  assign bus.Lead_count = lead_q;
  assign bus.Norm_out   = norm_q;

endmodule

// File: tb/tb_seq_normalizer.sv
// Directed bench for seq_normalizer: reset, CLZ/CLO table, backpressure, flush, mid-run reset.
// Latency: checks result exactly 5 edges after accept.
// Backpressure: holds Out_ready low and confirms the result is held.
module tb_seq_normalizer;
  import seq_normalizer_pkg::*;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;

  seq_normalizer_if bus ();

  seq_normalizer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        vec_op  [8];
  logic [31:0] vec_dat [8];
  logic [5:0]  vec_cnt [8];
  logic [31:0] vec_nrm [8];

  // Present one operation for the accept edge, then scramble the inputs
  task automatic send_op(input logic op, input logic [31:0] dat);
    bus.In_valid = 1'b1;
    bus.Op_sel   = op;
    bus.Norm_in  = dat;
    @(posedge clk); #1;
    bus.In_valid = 1'b0;
    bus.Op_sel   = ~op;
    bus.Norm_in  = $urandom;
  endtask

  // Wait (bounded) for Out_valid; returns edges elapsed since the call
  task automatic wait_valid(output int lat);
    lat = 0;
    while (bus.Out_valid !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.In_valid = 1'b0; bus.Op_sel = OP_CLZ; bus.Norm_in = '0;
    bus.Flush = 1'b0; bus.Out_ready = 1'b0;
    #2;
    checks++;
    if (bus.Out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", bus.Out_valid); end
    checks++;
    if (bus.In_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got=%b exp=0", bus.In_ready); end
    checks++;
    if (bus.Lead_count !== 6'd0) begin errors++; $display("FAIL reset_lead got=%0d exp=0", bus.Lead_count); end
    checks++;
    if (bus.Norm_out !== 32'h0) begin errors++; $display("FAIL reset_norm got=%h exp=0", bus.Norm_out); end
    @(posedge clk); @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.In_ready !== 1'b1) begin errors++; $display("FAIL reset_release_in_ready got=%b exp=1", bus.In_ready); end
  endtask

  task automatic test_ops();
    int lat;
    vec_op  = '{OP_CLZ, OP_CLZ, OP_CLZ, OP_CLO, OP_CLO, OP_CLO, OP_CLZ, OP_CLZ};
    vec_dat = '{32'h00000000, 32'h00010000, 32'h80000000, 32'hFFFFFFFF,
                32'hF0000000, 32'h7FFFFFFF, 32'h00000001, 32'h0000F00F};
    vec_cnt = '{6'd32, 6'd15, 6'd0, 6'd32, 6'd4, 6'd0, 6'd31, 6'd16};
    vec_nrm = '{32'h00000000, 32'h80000000, 32'h80000000, 32'h00000000,
                32'h00000000, 32'h7FFFFFFF, 32'h80000000, 32'hF00F0000};
    for (int i = 0; i < 8; i++) begin
      send_op(vec_op[i], vec_dat[i]);
      wait_valid(lat);
      checks++;
      if (lat !== 5) begin errors++; $display("FAIL op%0d_latency got=%0d exp=5", i, lat); end
      checks++;
      if (bus.Lead_count !== vec_cnt[i]) begin errors++; $display("FAIL op%0d_lead got=%0d exp=%0d", i, bus.Lead_count, vec_cnt[i]); end
      checks++;
      if (bus.Norm_out !== vec_nrm[i]) begin errors++; $display("FAIL op%0d_norm got=%h exp=%h", i, bus.Norm_out, vec_nrm[i]); end
      checks++;
      if (bus.In_ready !== 1'b0) begin errors++; $display("FAIL op%0d_in_ready_done got=%b exp=0", i, bus.In_ready); end
      bus.Out_ready = 1'b1;
      @(posedge clk); #1;
      bus.Out_ready = 1'b0;
      checks++;
      if (bus.Out_valid !== 1'b0 || bus.In_ready !== 1'b1) begin
        errors++; $display("FAIL op%0d_release got vld=%b rdy=%b exp vld=0 rdy=1", i, bus.Out_valid, bus.In_ready);
      end
    end
  endtask

  task automatic test_backpressure();
    int lat;
    bit seen;
    send_op(OP_CLZ, 32'h00000100);
    wait_valid(lat);
    checks++;
    if (lat !== 5) begin errors++; $display("FAIL bp_latency got=%0d exp=5", lat); end
    for (int c = 0; c < 3; c++) begin
      bus.In_valid = 1'b1; bus.Op_sel = OP_CLO; bus.Norm_in = 32'hFFFF0000;
      @(posedge clk); #1;
      checks++;
      if (bus.Out_valid !== 1'b1 || bus.In_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got vld=%b rdy=%b exp vld=1 rdy=0", c, bus.Out_valid, bus.In_ready);
      end
      checks++;
      if (bus.Lead_count !== 6'd23 || bus.Norm_out !== 32'h80000000) begin
        errors++; $display("FAIL bp_data%0d got lead=%0d norm=%h exp lead=23 norm=80000000", c, bus.Lead_count, bus.Norm_out);
      end
    end
    bus.In_valid = 1'b0;
    bus.Out_ready = 1'b1;
    @(posedge clk); #1;
    bus.Out_ready = 1'b0;
    checks++;
    if (bus.Out_valid !== 1'b0 || bus.In_ready !== 1'b1) begin
      errors++; $display("FAIL bp_release got vld=%b rdy=%b exp vld=0 rdy=1", bus.Out_valid, bus.In_ready);
    end
    seen = 1'b0;
    repeat (7) begin @(posedge clk); #1; if (bus.Out_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL bp_ignored_input got spurious Out_valid exp none"); end
  endtask

  task automatic test_flush();
    int lat;
    bit seen;
    send_op(OP_CLZ, 32'h00000001);
    @(posedge clk); #1;
    bus.Flush = 1'b1;
    @(posedge clk); #1;
    bus.Flush = 1'b0;
    checks++;
    if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0) begin
      errors++; $display("FAIL flush_idle got rdy=%b vld=%b exp rdy=1 vld=0", bus.In_ready, bus.Out_valid);
    end
    seen = 1'b0;
    repeat (7) begin @(posedge clk); #1; if (bus.Out_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_result got Out_valid after flush exp none"); end
    // Flush alongside In_valid in IDLE must not accept
    bus.Flush = 1'b1; bus.In_valid = 1'b1; bus.Op_sel = OP_CLZ; bus.Norm_in = 32'h00000010;
    @(posedge clk); #1;
    bus.Flush = 1'b0; bus.In_valid = 1'b0;
    seen = 1'b0;
    repeat (7) begin @(posedge clk); #1; if (bus.Out_valid === 1'b1) seen = 1'b1; end
    checks++;
    if (seen !== 1'b0 || bus.In_ready !== 1'b1) begin
      errors++; $display("FAIL flush_blocks_accept got seen=%b rdy=%b exp seen=0 rdy=1", seen, bus.In_ready);
    end
    send_op(OP_CLZ, 32'h00000001);
    wait_valid(lat);
    checks++;
    if (lat !== 5 || bus.Lead_count !== 6'd31 || bus.Norm_out !== 32'h80000000) begin
      errors++; $display("FAIL flush_next_op got lat=%0d lead=%0d norm=%h exp lat=5 lead=31 norm=80000000", lat, bus.Lead_count, bus.Norm_out);
    end
    bus.Out_ready = 1'b1;
    @(posedge clk); #1;
    bus.Out_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat;
    send_op(OP_CLZ, 32'h00000003);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.Out_valid !== 1'b0 || bus.Lead_count !== 6'd0 || bus.Norm_out !== 32'h0) begin
      errors++; $display("FAIL midreset_clear got vld=%b lead=%0d norm=%h exp 0/0/0", bus.Out_valid, bus.Lead_count, bus.Norm_out);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (bus.In_ready !== 1'b1 || bus.Out_valid !== 1'b0) begin
      errors++; $display("FAIL midreset_release got rdy=%b vld=%b exp rdy=1 vld=0", bus.In_ready, bus.Out_valid);
    end
    send_op(OP_CLZ, 32'h00000003);
    wait_valid(lat);
    checks++;
    if (lat !== 5 || bus.Lead_count !== 6'd30 || bus.Norm_out !== 32'hC0000000) begin
      errors++; $display("FAIL midreset_next_op got lat=%0d lead=%0d norm=%h exp lat=5 lead=30 norm=c0000000", lat, bus.Lead_count, bus.Norm_out);
    end
    bus.Out_ready = 1'b1;
    @(posedge clk); #1;
    bus.Out_ready = 1'b0;
  endtask

  initial begin
    errors = 0;
    checks = 0;
    test_reset();
    test_ops();
    test_backpressure();
    test_flush();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
